// File: rtl/me_search_if.sv
// Bus between the motion-estimation search controller and its environment:
// the start/done command pair, the PE operand enables and addresses, the
// absolute-difference return path and the search result.
// Handshake: start is a level request sampled only while the controller is
// idle, with no ready signal; done is a one-cycle pulse, and best_sad,
// best_mvx and best_mvy are valid in that cycle and hold until the next
// accepted start.
interface me_search_if #(
  parameter int N = 4,
  parameter int R = 2
);
  localparam int W   = N + 2 * R;
  localparam int SW  = 8 + $clog2(N * N);
  localparam int MVW = $clog2(R + 1) + 1;
  localparam int TAW = $clog2(N * N);
  localparam int SAW = $clog2(W * W);

  logic                  start;
  logic [7:0]            ad;
  logic                  en_tb;
  logic                  en_sw;
  logic [TAW-1:0]        tb_addr;
  logic [SAW-1:0]        sw_addr;
  logic                  busy;
  logic                  done;
  logic [SW-1:0]         best_sad;
  logic signed [MVW-1:0] best_mvx;
  logic signed [MVW-1:0] best_mvy;

  modport slave (
    input  start, ad,
    output en_tb, en_sw, tb_addr, sw_addr, busy, done,
           best_sad, best_mvx, best_mvy
  );

  modport master (
    output start, ad,
    input  en_tb, en_sw, tb_addr, sw_addr, busy, done,
           best_sad, best_mvx, best_mvy
  );
endinterface

// File: rtl/me_search_ctrl.sv
// Full-search block-matching controller. Walks every displacement of an
// N x N template over a (N+2R)^2 window, feeds pixel addresses to a
// one-cycle-latency absolute-difference PE, accumulates SAD per candidate
// and keeps the earliest minimum in raster order.
module me_search_ctrl #(
  parameter int N = 4,
  parameter int R = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  me_search_if.slave bus,
  output logic [1:0] o_dbg_state
);
  localparam int W   = N + 2 * R;
  localparam int SW  = 8 + $clog2(N * N);
  localparam int MVW = $clog2(R + 1) + 1;
  localparam int TAW = $clog2(N * N);
  localparam int SAW = $clog2(W * W);
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(2 * R + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0] r_px, r_py;
  logic [CW-1:0] r_mx, r_my;

  logic          r_vld_d, r_first_d, r_last_d;
  logic [CW-1:0] r_mx_d, r_my_d;
  logic [SW-1:0] r_acc;

  logic [SW-1:0]         r_best_sad;
  logic signed [MVW-1:0] r_best_mvx, r_best_mvy;

  logic w_start_acc;
  logic w_px_last, w_py_last, w_mx_last, w_my_last;
  logic w_pix_first, w_pix_last, w_all_last;
  logic [SW-1:0] w_ad_ext, w_cand_sad;
  logic signed [MVW-1:0] w_mvx, w_mvy;

  assign w_start_acc = (r_state == S_IDLE) && bus.start;
  assign w_px_last   = (r_px == PW'(N - 1));
  assign w_py_last   = (r_py == PW'(N - 1));
  assign w_mx_last   = (r_mx == CW'(2 * R));
  assign w_my_last   = (r_my == CW'(2 * R));
  assign w_pix_first = (r_px == '0) && (r_py == '0);
  assign w_pix_last  = w_px_last && w_py_last;
  assign w_all_last  = w_pix_last && w_mx_last && w_my_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: one pass over all candidates, one drain cycle for
  // the PE latency, then a single done cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_all_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy    = (r_state != S_IDLE);
    bus.done    = (r_state == S_DONE);
    bus.en_tb   = (r_state == S_RUN);
    bus.en_sw   = (r_state == S_RUN);
    o_dbg_state = r_state;
  end

  // Raster counters; they stop on the final pixel so the addresses hold
  // their last value until the next accepted start clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px <= '0;
      r_py <= '0;
      r_mx <= '0;
      r_my <= '0;
    end else if (w_start_acc) begin
      r_px <= '0;
      r_py <= '0;
      r_mx <= '0;
      r_my <= '0;
    end else if ((r_state == S_RUN) && !w_all_last) begin
      if (!w_px_last) begin
        r_px <= r_px + 1'b1;
      end else begin
        r_px <= '0;
        if (!w_py_last) begin
          r_py <= r_py + 1'b1;
        end else begin
          r_py <= '0;
          if (!w_mx_last) begin
            r_mx <= r_mx + 1'b1;
          end else begin
            r_mx <= '0;
            r_my <= r_my + 1'b1;
          end
        end
      end
    end
  end

  assign bus.tb_addr = TAW'(int'(r_py) * N + int'(r_px));
  assign bus.sw_addr = SAW'((int'(r_my) + int'(r_py)) * W + int'(r_mx) + int'(r_px));

  // Counter context delayed by one cycle to line up with ad from the PE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_d   <= 1'b0;
      r_first_d <= 1'b0;
      r_last_d  <= 1'b0;
      r_mx_d    <= '0;
      r_my_d    <= '0;
    end else begin
      r_vld_d   <= (r_state == S_RUN);
      r_first_d <= (r_state == S_RUN) && w_pix_first;
      r_last_d  <= (r_state == S_RUN) && w_pix_last;
      r_mx_d    <= r_mx;
      r_my_d    <= r_my;
    end
  end

  assign w_ad_ext   = SW'(bus.ad);
  assign w_cand_sad = r_first_d ? w_ad_ext : (r_acc + w_ad_ext);
  assign w_mvx      = MVW'(int'(r_mx_d) - R);
  assign w_mvy      = MVW'(int'(r_my_d) - R);

  // SAD accumulator, restarted on the first pixel of each candidate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_acc <= '0;
    else if (r_vld_d) r_acc <= w_cand_sad;
  end

  // Best-candidate tracking; strict less-than keeps the earlier candidate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_sad <= '0;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
    end else if (w_start_acc) begin
      r_best_sad <= '1;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
    end else if (r_vld_d && r_last_d && (w_cand_sad < r_best_sad)) begin
      r_best_sad <= w_cand_sad;
      r_best_mvx <= w_mvx;
      r_best_mvy <= w_mvy;
    end
  end

  assign bus.best_sad = r_best_sad;
  assign bus.best_mvx = r_best_mvx;
  assign bus.best_mvy = r_best_mvy;
endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: a PE model answers the controller's addresses,
// a reference search computes the expected result per start, and a monitor
// checks each done pulse against the expected queue.
module tb_me_search_ctrl;
  localparam int N   = 4;
  localparam int R   = 2;
  localparam int W   = N + 2 * R;
  localparam int D   = 2 * R + 1;
  localparam int C   = D * D;
  localparam int LAT = C * N * N + 2;

  typedef struct packed {
    int sad;
    int mvx;
    int mvy;
    int cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  me_search_if #(.N(N), .R(R)) bus ();

  me_search_ctrl #(.N(N), .R(R)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mode     = 0;   // 0: pixel images through the PE, 1: per-candidate ad
  exp_t exp_q[$];
  exp_t last_exp;
  logic [7:0] tpl[N*N];
  logic [7:0] win[W*W];
  logic [7:0] pat[C];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference search: plain SAD over every displacement, earliest minimum wins
  function automatic exp_t ref_search();
    exp_t e;
    int   s;
    e.sad = 32'h7fffffff;
    e.mvx = 0;
    e.mvy = 0;
    e.cyc = 0;
    for (int dy = 0; dy < D; dy++) begin
      for (int dx = 0; dx < D; dx++) begin
        s = 0;
        if (mode == 0) begin
          for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
              s += absdiff(int'(tpl[y*N+x]), int'(win[(dy+y)*W+dx+x]));
        end else begin
          s = N * N * int'(pat[dy*D+dx]);
        end
        if (s < e.sad) begin
          e.sad = s;
          e.mvx = dx - R;
          e.mvy = dy - R;
        end
      end
    end
    return e;
  endfunction

  // ---------------- PE model ----------------
  // Operands seen while enables are high come back as ad one cycle later;
  // any other cycle carries random garbage the controller must ignore.
  initial begin
    logic           en;
    logic [7:0]     ta;
    logic [7:0]     sa;
    int             en_cnt;
    int             idx;
    en_cnt = 0;
    idx    = 0;
    bus.ad = 8'd0;
    forever begin
      @(negedge clk);
      en = bus.en_sw;
      ta = 8'(bus.tb_addr);
      sa = 8'(bus.sw_addr);
      if (bus.en_tb != bus.en_sw) begin
        n_checks++;
        n_fail++;
        $display("FAIL en_pair: en_tb=%0d en_sw=%0d (cycle %0d)", bus.en_tb, bus.en_sw, cyc);
      end
      if (en) begin
        idx = en_cnt;
        en_cnt++;
      end else begin
        en_cnt = 0;
      end
      @(posedge clk);
      #1;
      if (!en) bus.ad = 8'($urandom_range(0, 255));
      else if (mode == 0) bus.ad = 8'(absdiff(int'(tpl[ta]), int'(win[sa])));
      else if (idx / (N * N) < C) bus.ad = pat[idx/(N*N)];
      else bus.ad = 8'd0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with nothing expected (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("best_sad", int'(bus.best_sad), e.sad);
        check("best_mvx", int'($signed(bus.best_mvx)), e.mvx);
        check("best_mvy", int'($signed(bus.best_mvy)), e.mvy);
        last_exp = e;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge with the DUT idle; start is sampled at
  // the next edge, so the current cycle number is the sampling cycle.
  task automatic pulse_start();
    exp_t e;
    e = ref_search();
    e.cyc = cyc + LAT;
    exp_q.push_back(e);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("search_finished_in_budget", (k < 1000) ? 1 : 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", int'(bus.busy), 0);
    check("hold_sad", int'(bus.best_sad), last_exp.sad);
    check("hold_mvx", int'($signed(bus.best_mvx)), last_exp.mvx);
  endtask

  task automatic set_pat(input int base, input int sel, input int val);
    for (int i = 0; i < C; i++) pat[i] = 8'(base);
    if (sel >= 0) pat[sel] = 8'(val);
  endtask

  task automatic rand_images(input int maxv);
    for (int i = 0; i < N * N; i++) tpl[i] = 8'($urandom_range(0, maxv));
    for (int i = 0; i < W * W; i++) win[i] = 8'($urandom_range(0, maxv));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_en_tb"}, int'(bus.en_tb), 0);
    check({tag, "_en_sw"}, int'(bus.en_sw), 0);
    check({tag, "_tb_addr"}, int'(bus.tb_addr), 0);
    check({tag, "_sw_addr"}, int'(bus.sw_addr), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_best_sad"}, int'(bus.best_sad), 0);
    check({tag, "_best_mvx"}, int'(bus.best_mvx), 0);
    check({tag, "_best_mvy"}, int'(bus.best_mvy), 0);
    check({tag, "_state"}, int'(dbg_state), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    rand_images(255);
    set_pat(0, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One good candidate in the middle, address sequence checked on the way
    mode = 1;
    set_pat(1, 2 * D + 2, 0);
    c0 = cyc;
    pulse_start();
    check("c1_busy", int'(bus.busy), 1);
    check("c1_en_tb", int'(bus.en_tb), 1);
    check("c1_tb_addr", int'(bus.tb_addr), 0);
    check("c1_sw_addr", int'(bus.sw_addr), 0);
    wait_until(c0 + 17);
    check("c17_tb_addr", int'(bus.tb_addr), 0);
    check("c17_sw_addr", int'(bus.sw_addr), 1);
    wait_until(c0 + 400);
    check("c400_en_sw", int'(bus.en_sw), 1);
    check("c400_tb_addr", int'(bus.tb_addr), N * N - 1);
    check("c400_sw_addr", int'(bus.sw_addr), W * W - 1);
    wait_until(c0 + 401);
    check("c401_en_sw", int'(bus.en_sw), 0);
    check("c401_busy", int'(bus.busy), 1);
    check("c401_sw_addr_hold", int'(bus.sw_addr), W * W - 1);
    wait_done();

    // All zero: tie resolves to the first candidate
    set_pat(0, -1, 0);
    pulse_start();
    wait_done();

    // Saturated window with one cheap corner candidate, then all saturated
    set_pat(255, C - 1, 1);
    pulse_start();
    wait_done();
    set_pat(255, -1, 0);
    pulse_start();
    wait_done();

    // Random per-candidate costs with frequent ties
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < C; i++) pat[i] = 8'($urandom_range(0, 3));
      pulse_start();
      wait_done();
    end

    // Random pixel images through the PE model
    mode = 0;
    for (int t = 0; t < 3; t++) begin
      rand_images((t == 0) ? 3 : 255);
      pulse_start();
      wait_done();
    end

    // Starts during a search and in the DONE cycle are ignored; start held
    // into the following idle cycle begins the next search
    rand_images(255);
    c0 = cyc;
    pulse_start();
    wait_until(c0 + 50);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_until(c0 + 402);
    check("ign_done_cycle", int'(bus.done), 1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("ign_idle_state", int'(dbg_state), 0);
    pulse_start();
    wait_done();
    check("ign_second_done", last_exp.cyc, c0 + 2 * LAT + 1);

    // Reset mid-search abandons it; a restart runs a full search
    rand_images(255);
    c0 = cyc;
    pulse_start();
    wait_until(c0 + 100);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (450) @(posedge clk);
    #1;
    rand_images(255);
    pulse_start();
    wait_done();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
